// File: rtl/vector_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vector_mem_ctrl: splits scalar/strided vector LSU requests into single     |
// | data-cache accesses and gathers load results into a slot buffer.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vector_mem_ctrl #(
   parameter int ADDR_WIDTH       = 17,
   parameter int DATA_LEN         = 32,
   parameter int VECTOR_SIZE      = 8,
   parameter int ENTRY_INDEX_SIZE = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [1:0]                        req_op,
   input  logic                              req_scalar,
   input  logic [ADDR_WIDTH-1:0]             req_addr,
   input  logic [ADDR_WIDTH-1:0]             req_stride,
   input  logic [2:0]                        req_vsew,
   input  logic [ENTRY_INDEX_SIZE:0]         req_vl,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0]   req_wdata,
   output logic                              resp_valid,
   output logic [VECTOR_SIZE*DATA_LEN-1:0]   resp_data,
   output logic                              resp_err,
   output logic [ADDR_WIDTH-1:0]             data_addr,
   output logic [2:0]                        data_type,
   output logic [DATA_LEN-1:0]               cache_written_data,
   output logic [1:0]                        cache_vis_signal,
   output logic [ENTRY_INDEX_SIZE:0]         length,
   input  logic [DATA_LEN-1:0]               data,
   input  logic [1:0]                        d_cache_vis_status
);

   localparam int CW = ENTRY_INDEX_SIZE + 1;

   localparam logic [1:0] D_CACHE_NOP   = 2'd0;
   localparam logic [1:0] D_CACHE_LOAD  = 2'd1;
   localparam logic [1:0] D_CACHE_STORE = 2'd2;

   localparam logic [1:0] D_CACHE_RESTING      = 2'd0;
   localparam logic [1:0] D_CACHE_L_S_FINISHED = 2'd3;

   localparam logic [2:0] ONE_BYTE   = 3'd0;
   localparam logic [2:0] FOUR_BYTE  = 3'd2;
   localparam logic [2:0] EIGHT_BYTE = 3'd3;

   localparam logic [CW-1:0] C_VS_N    = CW'(VECTOR_SIZE);
   localparam logic [CW:0]   C_VS_WIDE = {1'b0, C_VS_N};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GAP   = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                            r_state;
   state_t                            w_state_next;
   logic [1:0]                        r_op;
   logic                              r_eight;
   logic [2:0]                        r_vsew;
   logic [ADDR_WIDTH-1:0]             r_elem_addr;
   logic [ADDR_WIDTH-1:0]             r_stride;
   logic [VECTOR_SIZE*DATA_LEN-1:0]   r_wdata;
   logic [VECTOR_SIZE*DATA_LEN-1:0]   r_slots;
   logic [CW-1:0]                     r_k;
   logic [CW-1:0]                     r_n;
   logic                              r_trunc;

   logic                              w_accept;
   logic                              w_start;
   logic [CW:0]                       w_base_cnt;
   logic [CW:0]                       w_raw_cnt;
   logic                              w_trunc;
   logic [CW-1:0]                     w_req_n;
   logic [CW-1:0]                     w_k_inc;
   logic                              w_last;
   logic                              w_resting;
   logic                              w_finished;
   logic [31:0]                       w_slot_base;

   assign length     = CW'(1);
   assign w_accept   = req_valid && req_ready;
   assign w_start    = w_accept && (req_op != D_CACHE_NOP);
   assign w_resting  = (d_cache_vis_status == D_CACHE_RESTING);
   assign w_finished = (d_cache_vis_status == D_CACHE_L_S_FINISHED);

   // Each EIGHT_BYTE element costs two FOUR_BYTE accesses; overflow is clamped and flagged.
   assign w_base_cnt  = req_scalar ? {{CW{1'b0}}, 1'b1} : {1'b0, req_vl};
   assign w_raw_cnt   = (req_vsew == EIGHT_BYTE) ? (w_base_cnt << 1) : w_base_cnt;
   assign w_trunc     = (w_raw_cnt > C_VS_WIDE);
   assign w_req_n     = w_trunc ? C_VS_N : w_raw_cnt[CW-1:0];
   assign w_k_inc     = r_k + CW'(1);
   assign w_last      = (w_k_inc == r_n);
   assign w_slot_base = 32'(r_k[ENTRY_INDEX_SIZE-1:0]) * 32'(DATA_LEN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_next = (w_req_n == '0) ? DONE : GAP;
         GAP:     if (w_resting) w_state_next = ISSUE;
         ISSUE:   w_state_next = WAIT;
         WAIT:    if (w_finished) w_state_next = w_last ? DONE : GAP;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready          <= 1'b1;
         resp_valid         <= 1'b0;
         resp_err           <= 1'b0;
         resp_data          <= '0;
         data_addr          <= '0;
         data_type          <= ONE_BYTE;
         cache_written_data <= '0;
         cache_vis_signal   <= D_CACHE_NOP;
         r_op               <= D_CACHE_NOP;
         r_eight            <= 1'b0;
         r_vsew             <= ONE_BYTE;
         r_elem_addr        <= '0;
         r_stride           <= '0;
         r_wdata            <= '0;
         r_slots            <= '0;
         r_k                <= '0;
         r_n                <= '0;
         r_trunc            <= 1'b0;
      end else begin
         // Ready stays low during the response pulse so the two never overlap.
         req_ready  <= (w_state_next == IDLE) && (r_state != DONE);
         resp_valid <= (r_state == DONE);
         resp_err   <= (r_state == DONE) && r_trunc;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_op        <= req_op;
                  r_eight     <= (req_vsew == EIGHT_BYTE);
                  r_vsew      <= req_vsew;
                  r_elem_addr <= req_addr;
                  r_stride    <= req_stride;
                  r_wdata     <= req_wdata;
                  r_slots     <= '0;
                  r_k         <= '0;
                  r_n         <= w_req_n;
                  r_trunc     <= w_trunc;
               end
            end
            GAP: begin
               if (w_resting) begin
                  cache_vis_signal   <= r_op;
                  data_addr          <= (r_eight && r_k[0]) ? (r_elem_addr + ADDR_WIDTH'(4))
                                                            : r_elem_addr;
                  data_type          <= r_eight ? FOUR_BYTE : r_vsew;
                  cache_written_data <= r_wdata[w_slot_base +: DATA_LEN];
               end
            end
            ISSUE: cache_vis_signal <= D_CACHE_NOP;
            WAIT: begin
               if (w_finished) begin
                  if (r_op == D_CACHE_LOAD) r_slots[w_slot_base +: DATA_LEN] <= data;
                  r_k <= w_k_inc;
                  // The element address moves on only once both halves of an EIGHT_BYTE element are done.
                  if (!r_eight || r_k[0]) r_elem_addr <= r_elem_addr + r_stride;
               end
            end
            DONE: resp_data <= (r_op == D_CACHE_LOAD) ? r_slots : '0;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vector_mem_ctrl: randomized self-checking bench with a cache model and  |
// | a request-level reference model.   Revision: 1.0                           |
// +----------------------------------------------------------------------------+
module tb_vector_mem_ctrl;
   localparam int AW = 17;
   localparam int DL = 32;
   localparam int VS = 8;
   localparam int EIS = 3;
   localparam int WW = VS * DL;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [1:0]     req_op;
   logic           req_scalar;
   logic [AW-1:0]  req_addr;
   logic [AW-1:0]  req_stride;
   logic [2:0]     req_vsew;
   logic [EIS:0]   req_vl;
   logic [WW-1:0]  req_wdata;
   logic           resp_valid;
   logic [WW-1:0]  resp_data;
   logic           resp_err;
   logic [AW-1:0]  data_addr;
   logic [2:0]     data_type;
   logic [DL-1:0]  cache_written_data;
   logic [1:0]     cache_vis_signal;
   logic [EIS:0]   length;
   logic [DL-1:0]  c_data = '0;
   logic [1:0]     c_status = 2'd0;

   vector_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_LEN(DL), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_scalar(req_scalar),
      .req_addr(req_addr), .req_stride(req_stride), .req_vsew(req_vsew), .req_vl(req_vl),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .data_addr(data_addr), .data_type(data_type), .cache_written_data(cache_written_data),
      .cache_vis_signal(cache_vis_signal), .length(length),
      .data(c_data), .d_cache_vis_status(c_status)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [2:0]    typ;
      logic [1:0]    op;
      logic [DL-1:0] wdata;
   } acc_t;

   acc_t log_q[$];
   int   miss_cycles = 0;
   int   c_cnt = 0;

   function automatic logic [DL-1:0] mem_val(input logic [AW-1:0] a);
      if (a == 17'h100) return 32'hDEADBEEF;
      return 32'h5A000000 ^ ({15'd0, a} * 32'h9E3779B1);
   endfunction

   // Cache: accepts only while RESTING, optional busy period, FINISHED, then a rest cycle.
   always @(posedge clk) begin
      case (c_status)
         2'd0: if (cache_vis_signal != 2'd0) begin
            log_q.push_back('{data_addr, data_type, cache_vis_signal, cache_written_data});
            c_data <= mem_val(data_addr);
            if (miss_cycles == 0) c_status <= 2'd3;
            else begin
               c_status <= ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd2;
               c_cnt    <= miss_cycles;
            end
         end
         2'd1, 2'd2: begin
            if (c_cnt <= 1) c_status <= 2'd3;
            else begin
               c_cnt    <= c_cnt - 1;
               c_status <= ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd2;
            end
         end
         default: c_status <= 2'd0;
      endcase
   end

   logic [1:0] prev_status = 2'd0;
   always @(negedge clk) begin
      if (cache_vis_signal != 2'd0) check("handshake", {prev_status, c_status}, 4'b0000);
      if (resp_valid) check("ready_excl", req_ready, 1'b0);
      prev_status = c_status;
   end

   task automatic chk_reset(input string tag);
      check({tag, "_ready"}, req_ready, 1'b1);
      check({tag, "_rvalid"}, resp_valid, 1'b0);
      check({tag, "_rerr"}, resp_err, 1'b0);
      check({tag, "_rdata"}, resp_data, '0);
      check({tag, "_vis"}, cache_vis_signal, 2'd0);
      check({tag, "_addr"}, data_addr, '0);
      check({tag, "_type"}, data_type, 3'd0);
      check({tag, "_wdat"}, cache_written_data, '0);
      check({tag, "_len"}, length, 4'd1);
   endtask

   task automatic run_req(input string tag, input logic [1:0] op, input bit scalar,
                          input logic [AW-1:0] addr, input logic [AW-1:0] stride,
                          input logic [2:0] vsew, input logic [EIS:0] vl,
                          input logic [WW-1:0] wdata, input int miss, output int lat);
      acc_t          exp_q[$];
      acc_t          a;
      logic [WW-1:0] exp_data;
      bit            exp_err;
      bit            got;
      int            elems;
      int            per;
      int            idx;
      elems    = scalar ? 1 : int'(vl);
      per      = (vsew == 3'd3) ? 2 : 1;
      exp_err  = (elems * per > VS);
      exp_data = '0;
      for (int e = 0; e < elems; e++) begin
         for (int h = 0; h < per; h++) begin
            if (exp_q.size() < VS) begin
               idx     = exp_q.size();
               a.addr  = AW'(int'(addr) + e * int'(stride) + h * 4);
               a.typ   = (per == 2) ? 3'd2 : vsew;
               a.op    = op;
               a.wdata = wdata[idx*DL +: DL];
               if (op == 2'd1) exp_data[idx*DL +: DL] = mem_val(a.addr);
               exp_q.push_back(a);
            end
         end
      end
      miss_cycles = miss;
      log_q.delete();
      lat = 0;
      @(negedge clk);
      req_op = op; req_scalar = scalar; req_addr = addr; req_stride = stride;
      req_vsew = vsew; req_vl = vl; req_wdata = wdata; req_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin got = 1'b1; break; end
         @(negedge clk);
      end
      check({tag, "_accept"}, got, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 1'b0;
      if (op == 2'd0) begin
         repeat (10) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
         end
         check({tag, "_nop_resp"}, got, 1'b0);
         check({tag, "_nop_acc"}, log_q.size(), 0);
         check({tag, "_nop_ready"}, req_ready, 1'b1);
         return;
      end
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (resp_valid) begin got = 1'b1; break; end
      end
      check({tag, "_resp_seen"}, got, 1'b1);
      check({tag, "_data"}, resp_data, exp_data);
      check({tag, "_err"}, resp_err, exp_err);
      check({tag, "_nacc"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         check({tag, "_acc"},
               {log_q[i].addr, log_q[i].typ, log_q[i].op, (op == 2'd2) ? log_q[i].wdata : 32'd0},
               {exp_q[i].addr, exp_q[i].typ, exp_q[i].op, (op == 2'd2) ? exp_q[i].wdata : 32'd0});
      @(negedge clk);
      check({tag, "_pulse"}, resp_valid, 1'b0);
   endtask

   initial begin
      int            lat;
      bit            got;
      logic [WW-1:0] wd;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_scalar = 1'b0; req_addr = '0;
      req_stride = '0; req_vsew = '0; req_vl = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk_reset("rst0");
      rst = 1'b0;
      @(negedge clk);

      run_req("t1", 2'd1, 1'b1, 17'h100, 17'h0, 3'd2, 4'd0, '0, 0, lat);
      check("t1_latency", lat, 4);
      check("t1_slot0", resp_data[31:0], 32'hDEADBEEF);

      run_req("t2", 2'd1, 1'b0, 17'h20, 17'd3, 3'd0, 4'd4, '0, 0, lat);
      check("t2_upper_slots", resp_data[WW-1:4*DL], '0);

      for (int i = 0; i < VS; i++) wd[i*DL +: DL] = 32'h11110000 + i;
      run_req("t3", 2'd2, 1'b0, 17'h40, 17'd16, 3'd3, 4'd2, wd, 0, lat);

      run_req("t4", 2'd1, 1'b0, 17'h80, 17'd4, 3'd1, 4'd2, '0, 10, lat);

      run_req("t5a", 2'd1, 1'b0, 17'h1FFF8, 17'h1FFF0, 3'd3, 4'd8, '0, 0, lat);
      run_req("t5b", 2'd1, 1'b0, 17'h200, 17'd4, 3'd2, 4'd0, '0, 0, lat);
      run_req("nop", 2'd0, 1'b0, 17'h200, 17'd4, 3'd2, 4'd3, '0, 0, lat);

      // Reset while the second access of a load is still outstanding in the cache.
      miss_cycles = 6;
      log_q.delete();
      @(negedge clk);
      req_op = 2'd1; req_scalar = 1'b0; req_addr = 17'h300; req_stride = 17'd8;
      req_vsew = 3'd2; req_vl = 4'd4; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (log_q.size() >= 2) begin got = 1'b1; break; end
      end
      check("t6_second_issued", got, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("t6_rst");
      rst = 1'b0;
      run_req("t6_new", 2'd1, 1'b1, 17'h100, 17'h0, 3'd2, 4'd0, '0, 0, lat);

      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < VS; i++) wd[i*DL +: DL] = $urandom;
         run_req("rnd", ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd1, ($urandom_range(0, 3) == 0),
                 AW'($urandom), AW'($urandom), 3'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), wd, $urandom_range(0, 3), lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
